// File: rtl/wisc_pkg.sv
// Shared WISC decode definitions: destination-select encodings and register-file geometry.
package wisc_pkg;

  localparam int NREG   = 8;
  localparam int REG_AW = 3;

  localparam logic [REG_AW-1:0] R7 = 3'd7;

  typedef enum logic [1:0] {
    DST_RT = 2'd0,
    DST_RS = 2'd1,
    DST_RD = 2'd2,
    DST_R7 = 2'd3
  } dst_sel_e;

endpackage

// File: rtl/decode_pipe_stage_if.sv
// Decode-stage bus: IF/ID inputs, writeback, flush, and the registered ID/EX outputs.
interface decode_pipe_stage_if
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 24
);
  logic              if_valid;
  logic [15:0]       if_instr;
  logic [DATA_W-1:0] if_next_pc;
  logic [CTRL_W-1:0] ctrl;
  logic              ctrl_err;
  logic [1:0]        dst_sel;
  logic              reg_wrt;
  logic              mem_rd;
  logic              rs_used;
  logic              rt_used;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ex_flush;

  logic              stall_if;
  logic              id_valid;
  logic              id_reg_wrt;
  logic              id_mem_rd;
  logic [15:0]       id_instr;
  logic [DATA_W-1:0] id_next_pc;
  logic [CTRL_W-1:0] id_ctrl;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [REG_AW-1:0] id_wr_reg;
  logic              err;

  modport slave (
    input  if_valid, if_instr, if_next_pc, ctrl, ctrl_err, dst_sel, reg_wrt, mem_rd,
           rs_used, rt_used, wb_en, wb_addr, wb_data, ex_flush,
    output stall_if, id_valid, id_reg_wrt, id_mem_rd, id_instr, id_next_pc, id_ctrl,
           id_rd1, id_rd2, id_wr_reg, err
  );

  modport master (
    output if_valid, if_instr, if_next_pc, ctrl, ctrl_err, dst_sel, reg_wrt, mem_rd,
           rs_used, rt_used, wb_en, wb_addr, wb_data, ex_flush,
    input  stall_if, id_valid, id_reg_wrt, id_mem_rd, id_instr, id_next_pc, id_ctrl,
           id_rd1, id_rd2, id_wr_reg, err
  );

endinterface

// File: rtl/regfile_bypass.sv
// 8-entry register file, two read ports and one write port; writes land on the clock edge.
// With BYPASS=1 a write is forwarded to a matching read port in the same cycle.
module regfile_bypass
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) mem_q <= '{default: '0};
    else      mem_q <= mem_d;
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      assign rdata1 = (we && (waddr == raddr1)) ? wdata : mem_q[raddr1];
      assign rdata2 = (we && (waddr == raddr2)) ? wdata : mem_q[raddr2];
    end else begin : g_no_bypass
      assign rdata1 = mem_q[raddr1];
      assign rdata2 = mem_q[raddr2];
    end
  endgenerate

endmodule

// File: rtl/decode_pipe_stage.sv
// WISC decode stage with ID/EX register: operand read, destination select, load-use stall, flush.
// ID/EX outputs one cycle after IF/ID; a load-use hazard inserts one bubble and holds fetch.
module decode_pipe_stage
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 24,
  parameter int BYPASS = 1
) (
  input logic                clk,
  input logic                rst,
  decode_pipe_stage_if.slave bus
);

  logic [REG_AW-1:0] rs_addr, rt_addr, wr_sel;
  logic [DATA_W-1:0] rd1, rd2;
  logic              hz;

  logic              valid_q, valid_d;
  logic              reg_wrt_q, reg_wrt_d;
  logic              mem_rd_q, mem_rd_d;
  logic [15:0]       instr_q, instr_d;
  logic [DATA_W-1:0] next_pc_q, next_pc_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic [REG_AW-1:0] wr_reg_q, wr_reg_d;
  logic              err_q, err_d;

  assign rs_addr = bus.if_instr[10:8];
  assign rt_addr = bus.if_instr[7:5];

  regfile_bypass #(
    .DATA_W (DATA_W),
    .BYPASS (BYPASS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.wb_en),
    .waddr  (bus.wb_addr),
    .wdata  (bus.wb_data),
    .raddr1 (rs_addr),
    .rdata1 (rd1),
    .raddr2 (rt_addr),
    .rdata2 (rd2)
  );

  always_comb begin
    wr_sel = R7;
    case (dst_sel_e'(bus.dst_sel))
      DST_RT:  wr_sel = rt_addr;
      DST_RS:  wr_sel = rs_addr;
      DST_RD:  wr_sel = bus.if_instr[4:2];
      default: wr_sel = R7;
    endcase
  end

  // The load now in ID/EX cannot forward its data until it leaves MEM.
  assign hz = valid_q & mem_rd_q & reg_wrt_q & bus.if_valid &
              ((bus.rs_used & (rs_addr == wr_reg_q)) |
               (bus.rt_used & (rt_addr == wr_reg_q)));

  assign bus.stall_if = hz & ~bus.ex_flush;

  always_comb begin
    valid_d   = bus.if_valid;
    reg_wrt_d = bus.reg_wrt & bus.if_valid;
    mem_rd_d  = bus.mem_rd & bus.if_valid;
    instr_d   = bus.if_instr;
    next_pc_d = bus.if_next_pc;
    ctrl_d    = bus.ctrl;
    rd1_d     = rd1;
    rd2_d     = rd2;
    wr_reg_d  = wr_sel;
    err_d     = err_q | (bus.if_valid & bus.ctrl_err & ~bus.ex_flush & ~hz);
    if (bus.ex_flush || hz) begin
      valid_d   = 1'b0;
      reg_wrt_d = 1'b0;
      mem_rd_d  = 1'b0;
      ctrl_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      reg_wrt_q <= 1'b0;
      mem_rd_q  <= 1'b0;
      instr_q   <= '0;
      next_pc_q <= '0;
      ctrl_q    <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      wr_reg_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      reg_wrt_q <= reg_wrt_d;
      mem_rd_q  <= mem_rd_d;
      instr_q   <= instr_d;
      next_pc_q <= next_pc_d;
      ctrl_q    <= ctrl_d;
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      wr_reg_q  <= wr_reg_d;
      err_q     <= err_d;
    end
  end

  assign bus.id_valid   = valid_q;
  assign bus.id_reg_wrt = reg_wrt_q;
  assign bus.id_mem_rd  = mem_rd_q;
  assign bus.id_instr   = instr_q;
  assign bus.id_next_pc = next_pc_q;
  assign bus.id_ctrl    = ctrl_q;
  assign bus.id_rd1     = rd1_q;
  assign bus.id_rd2     = rd2_q;
  assign bus.id_wr_reg  = wr_reg_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Bench for decode_pipe_stage: two instances (bypass on/off, 32-bit datapath) on shared stimulus,
// checked by a scoreboard fed from a behavioural model of the decode/hazard rules.
module tb_decode_pipe_stage;
  import wisc_pkg::*;

  localparam int DW = 32;
  localparam int CW = 24;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  decode_pipe_stage_if #(.DATA_W(DW), .CTRL_W(CW)) bus_a ();
  decode_pipe_stage_if #(.DATA_W(DW), .CTRL_W(CW)) bus_b ();

  decode_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .BYPASS(1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave)
  );
  decode_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .BYPASS(0)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave)
  );

  assign bus_b.if_valid   = bus_a.if_valid;
  assign bus_b.if_instr   = bus_a.if_instr;
  assign bus_b.if_next_pc = bus_a.if_next_pc;
  assign bus_b.ctrl       = bus_a.ctrl;
  assign bus_b.ctrl_err   = bus_a.ctrl_err;
  assign bus_b.dst_sel    = bus_a.dst_sel;
  assign bus_b.reg_wrt    = bus_a.reg_wrt;
  assign bus_b.mem_rd     = bus_a.mem_rd;
  assign bus_b.rs_used    = bus_a.rs_used;
  assign bus_b.rt_used    = bus_a.rt_used;
  assign bus_b.wb_en      = bus_a.wb_en;
  assign bus_b.wb_addr    = bus_a.wb_addr;
  assign bus_b.wb_data    = bus_a.wb_data;
  assign bus_b.ex_flush   = bus_a.ex_flush;

  typedef struct {
    logic          rst_n;
    logic          valid;
    logic [15:0]   instr;
    logic [DW-1:0] pc;
    logic [CW-1:0] ctrl;
    logic          cerr;
    logic [1:0]    dsel;
    logic          reg_wrt, mem_rd, rs_used, rt_used;
    logic          wb_en;
    logic [2:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          flush;
  } stim_t;

  typedef struct {
    bit            full;
    bit            valid, reg_wrt, mem_rd, err;
    logic [15:0]   instr;
    logic [DW-1:0] pc;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] rd1a, rd2a, rd1b, rd2b;
    logic [2:0]    wr;
  } exp_t;

  typedef struct {
    bit chk;
    bit stall;
  } stall_t;

  exp_t   out_q[$];
  stall_t stall_q[$];
  stim_t  s;

  // Reference state: architectural registers plus a summary of what sits in ID/EX.
  logic [DW-1:0] mregs [8];
  bit            m_valid, m_mem_rd, m_reg_wrt, m_err, m_known;
  bit [2:0]      m_wr;
  bit            last_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int rs, input int rt, input int rd);
    logic [15:0] w;
    w = '0;
    w[10:8] = 3'(rs);
    w[7:5]  = 3'(rt);
    w[4:2]  = 3'(rd);
    return w;
  endfunction

  task automatic idle();
    s.rst_n = 1'b1; s.valid = 1'b0; s.instr = '0; s.pc = '0; s.ctrl = '0; s.cerr = 1'b0;
    s.dsel = 2'd0; s.reg_wrt = 1'b0; s.mem_rd = 1'b0; s.rs_used = 1'b0; s.rt_used = 1'b0;
    s.wb_en = 1'b0; s.wb_addr = '0; s.wb_data = '0; s.flush = 1'b0;
  endtask

  task automatic insn(input int rs, input int rt, input int rd, input logic [1:0] dsel);
    s.valid = 1'b1; s.instr = mk(rs, rt, rd); s.dsel = dsel;
    s.pc = 32'($urandom); s.ctrl = 24'($urandom) | 24'h1;
  endtask

  task automatic step();
    bit       hz;
    bit [2:0] rs, rt;
    exp_t     e;
    stall_t   st;
    @(negedge clk);
    rst              = s.rst_n;
    bus_a.if_valid   = s.valid;
    bus_a.if_instr   = s.instr;
    bus_a.if_next_pc = s.pc;
    bus_a.ctrl       = s.ctrl;
    bus_a.ctrl_err   = s.cerr;
    bus_a.dst_sel    = s.dsel;
    bus_a.reg_wrt    = s.reg_wrt;
    bus_a.mem_rd     = s.mem_rd;
    bus_a.rs_used    = s.rs_used;
    bus_a.rt_used    = s.rt_used;
    bus_a.wb_en      = s.wb_en;
    bus_a.wb_addr    = s.wb_addr;
    bus_a.wb_data    = s.wb_data;
    bus_a.ex_flush   = s.flush;
    #1;
    rs = s.instr[10:8];
    rt = s.instr[7:5];
    hz = m_valid && m_mem_rd && m_reg_wrt && s.valid &&
         ((s.rs_used && rs == m_wr) || (s.rt_used && rt == m_wr));
    st.chk   = m_known;
    st.stall = hz && !s.flush;
    stall_q.push_back(st);
    last_stall = hz && !s.flush;
    e = '{default: '0};
    if (!s.rst_n) begin
      e.full = 1'b1;
      foreach (mregs[i]) mregs[i] = '0;
      m_valid = 0; m_mem_rd = 0; m_reg_wrt = 0; m_err = 0; m_wr = 0; m_known = 1;
    end else begin
      if (s.flush || hz) begin
        m_valid = 0; m_mem_rd = 0; m_reg_wrt = 0;
      end else begin
        e.full    = 1'b1;
        e.valid   = s.valid;
        e.reg_wrt = s.valid && s.reg_wrt;
        e.mem_rd  = s.valid && s.mem_rd;
        e.instr   = s.instr;
        e.pc      = s.pc;
        e.ctrl    = s.ctrl;
        e.rd1a    = (s.wb_en && s.wb_addr == rs) ? s.wb_data : mregs[rs];
        e.rd2a    = (s.wb_en && s.wb_addr == rt) ? s.wb_data : mregs[rt];
        e.rd1b    = mregs[rs];
        e.rd2b    = mregs[rt];
        case (s.dsel)
          2'd0:    e.wr = rt;
          2'd1:    e.wr = rs;
          2'd2:    e.wr = s.instr[4:2];
          default: e.wr = 3'd7;
        endcase
        if (s.valid && s.cerr) m_err = 1;
        m_valid = e.valid; m_mem_rd = e.mem_rd; m_reg_wrt = e.reg_wrt; m_wr = e.wr;
      end
      if (s.wb_en) mregs[s.wb_addr] = s.wb_data;
      e.err = m_err;
    end
    out_q.push_back(e);
  endtask

  // Monitor: stall is checked mid-cycle, registered outputs just after the edge.
  initial begin
    stall_t st;
    exp_t   e;
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() != 0) begin
        st = stall_q.pop_front();
        if (st.chk) begin
          check("stall_a", 64'(bus_a.stall_if), 64'(st.stall));
          check("stall_b", 64'(bus_b.stall_if), 64'(st.stall));
        end
      end
      @(posedge clk);
      #1;
      if (out_q.size() != 0) begin
        e = out_q.pop_front();
        check("valid_a",   64'(bus_a.id_valid),   64'(e.valid));
        check("valid_b",   64'(bus_b.id_valid),   64'(e.valid));
        check("reg_wrt",   64'(bus_a.id_reg_wrt), 64'(e.reg_wrt));
        check("mem_rd",    64'(bus_a.id_mem_rd),  64'(e.mem_rd));
        check("ctrl",      64'(bus_a.id_ctrl),    64'(e.ctrl));
        check("err_a",     64'(bus_a.err),        64'(e.err));
        check("err_b",     64'(bus_b.err),        64'(e.err));
        if (e.full) begin
          check("instr",   64'(bus_a.id_instr),   64'(e.instr));
          check("next_pc", 64'(bus_a.id_next_pc), 64'(e.pc));
          check("wr_reg",  64'(bus_a.id_wr_reg),  64'(e.wr));
          check("wr_reg_b",64'(bus_b.id_wr_reg),  64'(e.wr));
          check("rd1_byp", 64'(bus_a.id_rd1),     64'(e.rd1a));
          check("rd2_byp", 64'(bus_a.id_rd2),     64'(e.rd2a));
          check("rd1_nob", 64'(bus_b.id_rd1),     64'(e.rd1b));
          check("rd2_nob", 64'(bus_b.id_rd2),     64'(e.rd2b));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    m_known = 0; m_valid = 0; m_mem_rd = 0; m_reg_wrt = 0; m_err = 0; m_wr = 0;
    last_stall = 0;
    foreach (mregs[i]) mregs[i] = '0;

    // Reset for two cycles, then write r3 and read it back with each destination select.
    idle(); s.rst_n = 1'b0; step(); step();
    idle(); s.wb_en = 1; s.wb_addr = 3'd3; s.wb_data = 32'h1234; step();
    idle(); insn(3, 1, 4, 2'd3); s.reg_wrt = 1; step();
    for (int d = 0; d < 3; d++) begin
      idle(); insn(3, 1, 4, 2'(d)); s.reg_wrt = 1; step();
    end

    // Same-cycle writeback of r5 against a read of r5, then a plain read.
    idle(); insn(0, 5, 1, 2'd0); s.wb_en = 1; s.wb_addr = 3'd5; s.wb_data = 32'hBEEF; step();
    idle(); insn(0, 5, 1, 2'd0); step();

    // Load-use: load to r2, dependent add stalls once then is captured.
    idle(); insn(0, 0, 2, 2'd2); s.mem_rd = 1; s.reg_wrt = 1; step();
    idle(); insn(2, 3, 4, 2'd2); s.rs_used = 1; s.reg_wrt = 1; step(); step();
    idle(); step();

    // False hazards: source unused, and load that does not write a register.
    idle(); insn(0, 0, 2, 2'd2); s.mem_rd = 1; s.reg_wrt = 1; step();
    idle(); insn(2, 3, 4, 2'd2); s.rt_used = 1; s.reg_wrt = 1; step();
    idle(); insn(0, 0, 2, 2'd2); s.mem_rd = 1; s.reg_wrt = 0; step();
    idle(); insn(2, 3, 4, 2'd2); s.rs_used = 1; s.reg_wrt = 1; step();

    // Flush during a hazard with an illegal opcode: no stall, bubble, no error.
    idle(); insn(0, 0, 2, 2'd2); s.mem_rd = 1; s.reg_wrt = 1; step();
    idle(); insn(2, 3, 4, 2'd2); s.rs_used = 1; s.flush = 1; s.cerr = 1; step();
    idle(); step();

    // Sticky error, wide round-trip through r7, then reset clears it.
    idle(); insn(1, 1, 1, 2'd0); s.cerr = 1; step();
    idle(); insn(1, 2, 3, 2'd1); step();
    idle(); s.wb_en = 1; s.wb_addr = 3'd7; s.wb_data = 32'hDEADBEEF; step();
    idle(); insn(7, 7, 0, 2'd3); step();

    // Reset asserted while a stall is pending.
    idle(); insn(0, 0, 2, 2'd2); s.mem_rd = 1; s.reg_wrt = 1; step();
    idle(); insn(2, 3, 4, 2'd2); s.rs_used = 1; s.rst_n = 0; step();
    idle(); insn(0, 3, 4, 2'd2); s.rt_used = 1; step();

    // Randomized traffic; fetch holds its instruction while the model reports a stall.
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) begin
        s.valid   = ($urandom_range(0, 9) != 0);
        s.instr   = 16'($urandom);
        s.instr[10:8] = 3'($urandom_range(0, 3));
        s.instr[7:5]  = 3'($urandom_range(0, 3));
        s.pc      = 32'($urandom);
        s.ctrl    = 24'($urandom);
        s.cerr    = ($urandom_range(0, 29) == 0);
        s.dsel    = 2'($urandom);
        s.reg_wrt = ($urandom_range(0, 3) != 0);
        s.mem_rd  = ($urandom_range(0, 2) == 0);
        s.rs_used = 1'($urandom);
        s.rt_used = 1'($urandom);
      end
      s.rst_n   = ($urandom_range(0, 79) != 0);
      s.wb_en   = 1'($urandom);
      s.wb_addr = 3'($urandom);
      s.wb_data = 32'($urandom);
      s.flush   = ($urandom_range(0, 9) == 0);
      step();
    end

    @(posedge clk);
    #3;
    check("drain", 64'(out_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_pipe_stage.md
# decode_pipe_stage

Parametrised decode stage with its ID/EX pipeline register for the 5-stage WISC pipeline, sitting between the IF/ID register and the execute stage. It owns the register file, which can optionally bypass a same-cycle writeback to its read ports. It selects the destination register, detects load-use hazards and stalls fetch, and handles flush from a taken branch or jump. Control decoding stays in the external control block; its output bundle enters through `ctrl` and is pipelined here unchanged.

## Interface
- `DATA_W`, 16: register, PC and writeback datapath width (>= 16).
- `CTRL_W`, 24: width of the opaque control bundle from the control block.
- `BYPASS`, 1: 1 = a writeback to a register is visible on the read port in the same cycle; 0 = visible from the next cycle.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `if_valid`  in  1  IF/ID holds a real instruction.
- `if_instr`  in  16  instruction word.
- `if_next_pc`  in  DATA_W  PC+2 of that instruction.
- `ctrl`  in  CTRL_W  control bundle for `if_instr`.
- `ctrl_err`  in  1  control block flagged an illegal opcode.
- `dst_sel`  in  2  destination select: 0 = instr[7:5], 1 = instr[10:8], 2 = instr[4:2], 3 = r7.
- `reg_wrt`, `mem_rd`  in  1 each  instruction writes a register / is a load.
- `rs_used`, `rt_used`  in  1 each  instr[10:8] / instr[7:5] is a true source.
- `wb_en`  in  1  writeback enable.
- `wb_addr`  in  3  writeback register.
- `wb_data`  in  DATA_W  writeback data.
- `ex_flush`  in  1  taken branch or jump resolved in EX.
- `stall_if`  out  1  hold PC and IF/ID this cycle.
- `id_valid`, `id_reg_wrt`, `id_mem_rd`  out  1 each  registered valid / reg-write / load.
- `id_instr`  out  16  registered instruction.
- `id_next_pc`  out  DATA_W  registered PC+2.
- `id_ctrl`  out  CTRL_W  registered control bundle.
- `id_rd1`, `id_rd2`  out  DATA_W  registered source data (rs, rt).
- `id_wr_reg`  out  3  registered destination register.
- `err`  out  1  sticky error flag.

## Operation
- **Register file:** 8 x DATA_W. It writes `wb_data` to `wb_addr` on the clock edge when `wb_en` = 1. Writes to r0 are stored; there is no hardwired zero.
- **Reads:** read 1 uses instr[10:8]; read 2 uses instr[7:5].
  - `BYPASS`=1: if `wb_en` is high and `wb_addr` equals the read address, the read returns `wb_data`.
  - `BYPASS`=0: the read always returns the stored value.
- **Hazard:** `hz` = `id_valid` & `id_mem_rd` & `id_reg_wrt` & `if_valid` & ((`rs_used` & instr[10:8] == `id_wr_reg`) | (`rt_used` & instr[7:5] == `id_wr_reg`)).
- **Stall:** `stall_if` = `hz` & !`ex_flush`. It is combinational.
- **Edge behaviour, in priority order:**
  1. Reset: every ID/EX field, `err` and every register goes to 0.
  2. `ex_flush`: load a bubble. A bubble sets `id_valid`, `id_reg_wrt` and `id_mem_rd` to 0, and `id_ctrl` to 0; the other fields don't care.
  3. `hz`: load a bubble. IF/ID holds, and the same instruction is re-evaluated next cycle.
  4. Otherwise: capture all inputs. `id_valid` = `if_valid`; `id_reg_wrt` = `reg_wrt` & `if_valid`; `id_mem_rd` = `mem_rd` & `if_valid`.
- **Error:** `err` sets on an edge where `if_valid` & `ctrl_err` & !`ex_flush` & !`hz`. It clears only on reset.

## Timing
- ID/EX outputs appear one cycle after the IF/ID inputs are presented.
- A load-use hazard costs exactly one bubble. Next cycle the load has moved to EX, so `hz` is 0.
- When `wb_en` and a hazard occur in the same cycle, the register file still writes.
- `ex_flush` during `hz` drops `stall_if` to 0 in that cycle.
- Reset asserted mid-stall clears everything on that edge. `stall_if` is 0 in the first cycle after reset because `id_valid` is 0.
- Reset values: all outputs are 0, including `stall_if`.

## Structure
- Shared package `wisc_pkg` holds:
  - the `dst_sel` encodings (`DST_RT`, `DST_RS`, `DST_RD`, `DST_R7`);
  - `NREG` = 8 and `REG_AW` = 3;
  - the `R7` constant.
- Sub-module `regfile_bypass` is parametrised by `DATA_W` and `BYPASS`. It has two read ports, one write port and a synchronous active-low reset. The hazard logic and the ID/EX register live in the top level.

## Test plan
- **Reset and basic capture:** hold `rst`=0 for 2 cycles → all outputs 0. Release, then write r3=0x1234 via `wb`. Next cycle, present an instruction with rs=r3 → `id_rd1`=0x1234 one cycle later; `id_wr_reg` follows `dst_sel`, with `dst_sel`=3 giving 7.
- **Bypass:** `wb_en`=1, `wb_addr`=5, `wb_data`=0xBEEF in the same cycle as a read of r5.
  - `BYPASS`=1 → `id_rd2`=0xBEEF.
  - `BYPASS`=0 → old value of r5.
- **Load-use:** load with `dst_sel` → r2, then an add with rs=r2 and `rs_used`=1 → `stall_if`=1 for exactly one cycle, one bubble (`id_valid`=0), then the add is captured.
- **False hazard:** repeat the load-use case with `rs_used`=0, or with the load having `reg_wrt`=0 → no stall.
- **Flush during hazard:** stall condition plus `ex_flush`=1 → `stall_if`=0 and a bubble loaded. With `ctrl_err` also high → `err` stays 0.
- **Sticky error and width:** `DATA_W`=32; a `ctrl_err` instruction accepted → `err`=1 and stays 1 through later valid instructions, until `rst`=0. A 32-bit `wb_data` 0xDEADBEEF round-trips through r7.
